if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline; sits directly upstream of the ID-stage control unit.
- Owns the PC and selects the next PC from the ID-stage pcsource/target inputs.
- Drives a single-outstanding instruction-memory request interface and presents instruction/PC+4 to ID.
- Honours the load-use stall (wpcir) and the architectural branch delay slot.

Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset.
- NOP_INST, 32'h00000000, instruction word presented to ID on a bubble (sll $0,$0,0).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- wpcir  in  1  1 = load-use stall: hold PC and IF/ID, ignore pcsource this cycle
- pcsource  in  2  00 PC+4, 01 branch (bpc), 10 register jump jr/jalr (rpc), 11 j/jal (jpc)
- bpc  in  32  branch target from ID
- rpc  in  32  register target (forwarded rs) from ID
- jpc  in  32  jump target from ID
- imem_req  out  1  one-cycle fetch request strobe
- imem_addr  out  32  fetch address, valid with imem_req
- imem_valid  in  1  response strobe, at least 1 cycle after the request
- imem_rdata  in  32  instruction, valid with imem_valid
- id_inst  out  32  IF/ID instruction
- id_pc4  out  32  IF/ID PC+4, used by jal/jalr link
- id_valid  out  1  1 = id_inst is a real instruction, 0 = bubble

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (resetn).
- Reset values (resetn=0 at a clk edge):
  - pc_reg=RESET_PC; state=RUN.
  - imem_req=0; id_inst=NOP_INST; id_pc4=0; id_valid=0; holding buffer empty.
- pc_reg holds the next address to request.
- Redirect:
  - Redirect condition: redir = id_valid & ~wpcir & (pcsource != 00).
  - Redirect target: tgt = bpc / rpc / jpc according to pcsource.
  - Issue address: imem_addr = redir ? tgt : pc_reg.
- On each issue, pc_reg <= imem_addr + 4. On redir without an issue, pc_reg <= tgt.
  - This is what keeps the delay slot: the slot address (branch PC+4) was already requested when the branch entered ID, so the redirect only affects the following request.
- States:
  - RUN: no request outstanding.
  - WAIT: one request outstanding.
  - HOLD: response buffered while ID is stalled.
- RUN:
  - wpcir=0 → issue, go to WAIT.
  - wpcir=1 → no issue, stay.
  - IF/ID loads a bubble if wpcir=0; holds if wpcir=1.
- WAIT, imem_valid=0:
  - IF/ID loads a bubble if wpcir=0; holds if wpcir=1.
- WAIT, imem_valid=1 and wpcir=0:
  - IF/ID <= {imem_rdata, fetched_pc+4, valid=1}.
  - Issue the next request in the same cycle and stay in WAIT. Back-to-back throughput is 1 instruction per cycle at memory latency 1.
- WAIT, imem_valid=1 and wpcir=1:
  - Capture the response into the holding buffer, no issue, go to HOLD.
- HOLD:
  - wpcir=1 → stay, IF/ID held.
  - wpcir=0 → deliver the buffer to IF/ID, issue the next request, go to WAIT.
- Boundary conditions:
  - At most one outstanding request. Never assert imem_req in WAIT unless imem_valid=1 that cycle.
  - A stray imem_valid in RUN or HOLD is ignored.
  - wpcir=1 with a pending redirect: redirect is not taken; it is re-evaluated when wpcir drops, since the branch is still in ID.
  - fetched_pc is registered at issue; id_pc4 = fetched_pc + 4, 32-bit wrap-around (0xFFFFFFFC+4 → 0).
  - Reset mid-request: the outstanding response is dropped. Any imem_valid arriving in RUN after reset is ignored, and the first post-reset request goes to RESET_PC.

Optional Feature:
- Macro: IF_ADEL_EN.
- Defined:
  - Adds output id_adel (1 bit, reset 0).
  - If an issue address has addr[1:0] != 0, no imem_req is asserted. The next IF/ID load is NOP_INST with id_valid=1, id_adel=1, id_pc4 = bad address + 4, and state returns to RUN.
- Undefined: no id_adel port; addr[1:0] is passed through unchecked.

Decomposition:
- Shared package: PCSRC_SEQ/BR/JR/J (2-bit pcsource encodings), NOP_INST, RESET_PC default, fetch state enum {RUN, WAIT, HOLD}.
- One natural sub-module: if_id_reg (IF/ID register with hold and bubble-insert).
- Next-PC mux and FSM stay in if_stage.

Test Plan:
- Reset: resetn low 2 cycles, then high, latency-1 memory → imem_addr=BFC00000, then BFC00004, BFC00008 on consecutive cycles; id_valid=1 from cycle 2.
- Branch taken: beq at BFC00010, pcsource=01, bpc=BFC00100 →
  - ID sees BFC00010, then delay slot BFC00014, then BFC00100.
  - No BFC00018 request.
- Stall: wpcir=1 for 2 cycles while a response returns →
  - id_inst/id_pc4 frozen; response buffered (HOLD).
  - On release, buffered instruction delivered with no duplicate or loss.
- Jr with stall: pcsource=10, rpc=00400000 under wpcir=1, then wpcir=0 →
  - No redirect during the stall.
  - Next issue after the delay slot is 00400000.
- Slow memory (latency 3) → two bubbles (id_valid=0, id_inst=0) between instructions; never two outstanding requests.
- IF_ADEL_EN: jpc=00400002 →
  - No imem_req to 00400002.
  - id_adel=1, id_inst=0, id_pc4=00400006.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: pcsource encodings,
// reset/bubble constants and the fetch FSM state type.
package if_stage_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    FS_RUN  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic addr_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: load has priority over hold; otherwise a bubble
// (NOP, valid=0) is inserted. Optional address-error flag under IF_ADEL_EN.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic        hold_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc4_i,
`ifdef IF_ADEL_EN
  input  logic        adel_i,
  output logic        adel_o,
`endif
  output logic [31:0] inst_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] inst_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  // IF/ID instruction, link address and valid flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      inst_q  <= NOP_INST;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end else if (hold_i) begin
      inst_q  <= inst_q;
      pc4_q   <= pc4_q;
      valid_q <= valid_q;
    end else begin
      inst_q  <= NOP_INST;
      pc4_q   <= pc4_q;
      valid_q <= 1'b0;
    end
  end

`ifdef IF_ADEL_EN
  logic adel_q;

  // Address-error flag travels with the IF/ID entry
  always_ff @(posedge clk) begin
    if (!resetn) begin
      adel_q <= 1'b0;
    end else if (load_i) begin
      adel_q <= adel_i;
    end else if (hold_i) begin
      adel_q <= adel_q;
    end else begin
      adel_q <= 1'b0;
    end
  end

  assign adel_o = adel_q;
`endif

  assign inst_o  = inst_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with single-outstanding imem interface and IF/ID
// register. Optional misaligned-fetch detection enabled by macro IF_ADEL_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
`ifdef IF_ADEL_EN
  output logic        id_adel,
`endif
  output logic        id_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetched_pc_q, fetched_pc_d;
  logic [31:0]  buf_q, buf_d;

  logic         redir_s;
  logic [31:0]  tgt_s;
  logic [31:0]  addr_s;
  logic         issue_s;
  logic         req_s;
  logic         load_s;
  logic [31:0]  ld_inst_s;
  logic [31:0]  ld_pc4_s;
  logic         ld_adel_s;
`ifdef IF_ADEL_EN
  logic         adel_pend_q, adel_pend_d;
`endif

  // Redirect target selection; only meaningful when pcsource != SEQ
  always_comb begin
    tgt_s = pc_q;
    case (pcsource)
      PCSRC_BR: tgt_s = bpc;
      PCSRC_JR: tgt_s = rpc;
      PCSRC_J:  tgt_s = jpc;
      default:  tgt_s = pc_q;
    endcase
  end

  // The branch in ID only steers the request after its delay slot
  assign redir_s = id_valid & ~wpcir & (pcsource != PCSRC_SEQ);
  assign addr_s  = redir_s ? tgt_s : pc_q;

  // Fetch FSM next state, issue decision and IF/ID load data
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetched_pc_d = fetched_pc_q;
    buf_d        = buf_q;
    issue_s      = 1'b0;
    req_s        = 1'b0;
    load_s       = 1'b0;
    ld_inst_s    = imem_rdata;
    ld_pc4_s     = fetched_pc_q + 32'd4;
    ld_adel_s    = 1'b0;
`ifdef IF_ADEL_EN
    adel_pend_d  = adel_pend_q;
`endif
    case (state_q)
      FS_RUN: begin
`ifdef IF_ADEL_EN
        if (adel_pend_q) begin
          if (!wpcir) begin
            load_s      = 1'b1;
            ld_inst_s   = NOP_INST;
            ld_adel_s   = 1'b1;
            adel_pend_d = 1'b0;
          end else begin
            load_s = 1'b0;
          end
        end else begin
          issue_s = ~wpcir;
        end
`else
        issue_s = ~wpcir;
`endif
      end
      FS_WAIT: begin
        if (imem_valid && !wpcir) begin
          load_s  = 1'b1;
          issue_s = 1'b1;
        end else if (imem_valid) begin
          buf_d   = imem_rdata;
          state_d = FS_HOLD;
        end else begin
          state_d = FS_WAIT;
        end
      end
      FS_HOLD: begin
        if (!wpcir) begin
          load_s    = 1'b1;
          ld_inst_s = buf_q;
          issue_s   = 1'b1;
        end else begin
          state_d = FS_HOLD;
        end
      end
      default: begin
        state_d = FS_RUN;
      end
    endcase

    if (issue_s) begin
      fetched_pc_d = addr_s;
      pc_d         = addr_s + 32'd4;
      state_d      = FS_WAIT;
      req_s        = resetn;
`ifdef IF_ADEL_EN
      if (addr_misaligned(addr_s)) begin
        state_d     = FS_RUN;
        adel_pend_d = 1'b1;
        req_s       = 1'b0;
      end else begin
        adel_pend_d = adel_pend_q;
      end
`endif
    end else if (redir_s) begin
      pc_d = tgt_s;
    end else begin
      pc_d = pc_q;
    end
  end

  // Fetch state, PC, issued address and stall buffer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= FS_RUN;
      pc_q         <= RESET_PC;
      fetched_pc_q <= RESET_PC;
      buf_q        <= NOP_INST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetched_pc_q <= fetched_pc_d;
      buf_q        <= buf_d;
    end
  end

`ifdef IF_ADEL_EN
  // Pending address error waiting to be handed to ID
  always_ff @(posedge clk) begin
    if (!resetn) begin
      adel_pend_q <= 1'b0;
    end else begin
      adel_pend_q <= adel_pend_d;
    end
  end
`endif

  assign imem_req  = req_s;
  assign imem_addr = addr_s;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (load_s),
    .hold_i  (wpcir),
    .inst_i  (ld_inst_s),
    .pc4_i   (ld_pc4_s),
`ifdef IF_ADEL_EN
    .adel_i  (ld_adel_s),
    .adel_o  (id_adel),
`endif
    .inst_o  (id_inst),
    .pc4_o   (id_pc4),
    .valid_o (id_valid)
  );

`ifndef IF_ADEL_EN
  logic unused_s;
  assign unused_s = ld_adel_s;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a latency-programmable memory model and a
// tiny "decoder" that raises pcsource when a chosen PC sits in ID.
module tb_if_stage;

  logic        clk;
  logic        resetn;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
`ifdef IF_ADEL_EN
  logic        id_adel;
`endif

  int checks = 0;
  int errors = 0;

  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  logic        mem_pend = 1'b0;
  logic [31:0] mem_addr = 32'h0;

  logic [31:0] br_pc  = 32'hBFC0_0010;
  logic [1:0]  br_src = 2'b01;
  logic [31:0] tgt_b  = 32'hBFC0_0100;
  logic [31:0] tgt_r  = 32'h0040_0000;
  logic [31:0] tgt_j  = 32'hBFC0_0200;

  logic [31:0] ea [0:9];

  if_stage dut (
    .clk        (clk),
    .resetn     (resetn),
    .wpcir      (wpcir),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .id_inst    (id_inst),
    .id_pc4     (id_pc4),
`ifdef IF_ADEL_EN
    .id_adel    (id_adel),
`endif
    .id_valid   (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs #1 after posedge, sample/capture at negedge
  task automatic cyc(input logic stall, input logic rn);
    @(posedge clk);
    #1;
    resetn     = rn;
    wpcir      = stall;
    imem_valid = 1'b0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_valid = 1'b1;
        imem_rdata = ~mem_addr;
        mem_pend   = 1'b0;
      end
    end
    pcsource = ((id_valid === 1'b1) && (id_pc4 == br_pc + 32'd4)) ? br_src : 2'b00;
    bpc = tgt_b;
    rpc = tgt_r;
    jpc = tgt_j;
    @(negedge clk);
    if (imem_req === 1'b1) begin
      chk("one_outstanding", 32'(mem_pend), 32'd0);
      mem_pend = 1'b1;
      mem_cnt  = mem_lat;
      mem_addr = imem_addr;
    end
  endtask

  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc4, input logic [31:0] inst);
    chk({tag, "_valid"}, 32'(id_valid), 32'(v));
    chk({tag, "_inst"}, id_inst, inst);
    if (v) chk({tag, "_pc4"}, id_pc4, pc4);
  endtask

  initial begin
    resetn     = 1'b0;
    wpcir      = 1'b0;
    pcsource   = 2'b00;
    bpc        = 32'h0;
    rpc        = 32'h0;
    jpc        = 32'h0;
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    ea = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00008, 32'hBFC0000C, 32'hBFC00010,
           32'hBFC00014, 32'hBFC00100, 32'hBFC00104, 32'hBFC00108, 32'hBFC0010C};

    // Reset state
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);

    // Startup stream and taken branch with delay slot
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b1);
      chk("br_req", 32'(imem_req), 32'd1);
      chk("br_addr", imem_addr, ea[k]);
      if (k >= 2) chk_id("br_id", 1'b1, ea[k-2] + 32'd4, ~ea[k-2]);
      else        chk("br_novalid", 32'(id_valid), 32'd0);
    end

    // Stall while a response returns
    cyc(1'b0, 1'b1); chk("st_addr0", imem_addr, 32'hBFC00110);
    cyc(1'b1, 1'b1); chk("st_req1", 32'(imem_req), 32'd0); chk_id("st_id1", 1'b1, 32'hBFC00110, ~32'hBFC0010C);
    cyc(1'b1, 1'b1); chk("st_req2", 32'(imem_req), 32'd0); chk_id("st_id2", 1'b1, 32'hBFC00110, ~32'hBFC0010C);
    cyc(1'b0, 1'b1); chk("st_addr3", imem_addr, 32'hBFC00114); chk_id("st_id3", 1'b1, 32'hBFC00110, ~32'hBFC0010C);
    cyc(1'b0, 1'b1); chk("st_addr4", imem_addr, 32'hBFC00118); chk_id("st_id4", 1'b1, 32'hBFC00114, ~32'hBFC00110);
    cyc(1'b0, 1'b1); chk("st_addr5", imem_addr, 32'hBFC0011C); chk_id("st_id5", 1'b1, 32'hBFC00118, ~32'hBFC00114);

    // jr at BFC00120 held in ID by a stall
    br_pc  = 32'hBFC0_0120;
    br_src = 2'b10;
    cyc(1'b0, 1'b1); chk("jr_addr0", imem_addr, 32'hBFC00120);
    cyc(1'b0, 1'b1); chk("jr_addr1", imem_addr, 32'hBFC00124);
    cyc(1'b1, 1'b1); chk("jr_req2", 32'(imem_req), 32'd0); chk_id("jr_id2", 1'b1, 32'hBFC00124, ~32'hBFC00120);
    cyc(1'b1, 1'b1); chk("jr_req3", 32'(imem_req), 32'd0); chk_id("jr_id3", 1'b1, 32'hBFC00124, ~32'hBFC00120);
    cyc(1'b0, 1'b1); chk("jr_req4", 32'(imem_req), 32'd1); chk("jr_addr4", imem_addr, 32'h00400000);
    cyc(1'b0, 1'b1); chk("jr_addr5", imem_addr, 32'h00400004); chk_id("jr_id5", 1'b1, 32'hBFC00128, ~32'hBFC00124);
    cyc(1'b0, 1'b1); chk("jr_addr6", imem_addr, 32'h00400008); chk_id("jr_id6", 1'b1, 32'h00400004, ~32'h00400000);

    // Slow memory, latency 3
    mem_lat = 3;
    cyc(1'b0, 1'b1); chk("sl_addr0", imem_addr, 32'h0040000C); chk_id("sl_id0", 1'b1, 32'h00400008, ~32'h00400004);
    cyc(1'b0, 1'b1); chk("sl_req1", 32'(imem_req), 32'd0); chk_id("sl_id1", 1'b1, 32'h0040000C, ~32'h00400008);
    cyc(1'b0, 1'b1); chk("sl_req2", 32'(imem_req), 32'd0); chk_id("sl_id2", 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1); chk("sl_addr3", imem_addr, 32'h00400010); chk_id("sl_id3", 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1); chk("sl_req4", 32'(imem_req), 32'd0); chk_id("sl_id4", 1'b1, 32'h00400010, ~32'h0040000C);
    cyc(1'b0, 1'b1); chk_id("sl_id5", 1'b0, 32'h0, 32'h0);
    cyc(1'b0, 1'b1); chk("sl_addr6", imem_addr, 32'h00400014); chk_id("sl_id6", 1'b0, 32'h0, 32'h0);

    // Reset with a request outstanding; late response must be dropped
    mem_lat = 1;
    cyc(1'b0, 1'b0); chk_id("mr_id0", 1'b1, 32'h00400014, ~32'h00400010);
    br_pc  = 32'hBFC0_0008;
    br_src = 2'b11;
    tgt_j  = 32'hFFFF_FFF8;
    cyc(1'b0, 1'b0); chk("mr_req1", 32'(imem_req), 32'd0); chk_id("mr_id1", 1'b0, 32'h0, 32'h0);
    chk("mr_pc4_1", id_pc4, 32'h0);
    cyc(1'b0, 1'b1); chk("mr_stray", 32'(imem_valid), 32'd1); chk("mr_addr2", imem_addr, 32'hBFC00000);
    cyc(1'b0, 1'b1); chk("mr_valid3", 32'(id_valid), 32'd0); chk("mr_addr3", imem_addr, 32'hBFC00004);
    cyc(1'b0, 1'b1); chk_id("mr_id4", 1'b1, 32'hBFC00004, ~32'hBFC00000); chk("mr_addr4", imem_addr, 32'hBFC00008);

    // j to the top of the address space: PC+4 wraps to zero
    cyc(1'b0, 1'b1); chk("wr_addr0", imem_addr, 32'hBFC0000C);
    cyc(1'b0, 1'b1); chk("wr_addr1", imem_addr, 32'hFFFFFFF8); chk_id("wr_id1", 1'b1, 32'hBFC0000C, ~32'hBFC00008);
    cyc(1'b0, 1'b1); chk("wr_addr2", imem_addr, 32'hFFFFFFFC); chk_id("wr_id2", 1'b1, 32'hBFC00010, ~32'hBFC0000C);
    cyc(1'b0, 1'b1); chk("wr_addr3", imem_addr, 32'h00000000); chk_id("wr_id3", 1'b1, 32'hFFFFFFFC, ~32'hFFFFFFF8);
    cyc(1'b0, 1'b1); chk("wr_addr4", imem_addr, 32'h00000004); chk_id("wr_id4", 1'b1, 32'h00000000, 32'h00000003);

`ifdef IF_ADEL_EN
    // j at 0x8 to a misaligned target
    br_pc  = 32'h0000_0008;
    br_src = 2'b11;
    tgt_j  = 32'h0040_0002;
    cyc(1'b0, 1'b1); chk("ad_addr0", imem_addr, 32'h00000008);
    cyc(1'b0, 1'b1); chk("ad_addr1", imem_addr, 32'h0000000C);
    cyc(1'b0, 1'b1); chk("ad_req2", 32'(imem_req), 32'd0); chk("ad_addr2", imem_addr, 32'h00400002);
    cyc(1'b0, 1'b1); chk("ad_req3", 32'(imem_req), 32'd0); chk_id("ad_id3", 1'b1, 32'h00000010, ~32'h0000000C);
    chk("ad_flag3", 32'(id_adel), 32'd0);
    cyc(1'b0, 1'b1); chk_id("ad_id4", 1'b1, 32'h00400006, 32'h0); chk("ad_flag4", 32'(id_adel), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
